// File: rtl/resolution_text_painter.sv
// Resolution text painter: follows the raster from frame/line/pixel strobes,
// fetches one ROM line per active text row, and serialises it MSB-first into a
// 1-bit overlay pixel, replicated SCALE times in X and Y at a fixed window.
// Handshake: pixel_valid is a one-cycle strobe with no back-pressure; every
// pulse is one pixel. text_active/text_pixel describe the pixel strobed in the
// previous cycle and are both 0 when no pixel was strobed.
module resolution_text_painter #(
    parameter int LINE_BITS = 192,
    parameter int ROWS      = 16,
    parameter int POS_X     = 16,
    parameter int POS_Y     = 16,
    parameter int SCALE     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 line_start,
    input  logic                 pixel_valid,
    output logic [3:0]           rom_addr,
    input  logic [LINE_BITS-1:0] rom_q,
    output logic                 text_pixel,
    output logic                 text_active
);

    localparam int BW = $clog2(LINE_BITS + 1);
    localparam logic [11:0]   WIN_LO   = 12'(POS_Y);
    localparam logic [11:0]   WIN_HI   = 12'(POS_Y + ROWS * SCALE);
    localparam logic [11:0]   FIRST_X  = 12'(POS_X);
    localparam logic [11:0]   SCALE12  = 12'(SCALE);
    localparam logic [1:0]    REP_LAST = 2'(SCALE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(LINE_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        LOAD  = 3'd3,
        ARMED = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t               state, state_nxt;
    logic [11:0]          line_cnt, pix_cnt;
    logic [11:0]          line_nxt, pix_idx, row_off;
    logic [LINE_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic [1:0]           rep_cnt;
    logic                 in_window, paint, rep_wrap, last_bit;

    // Raster bookkeeping: the line number this cycle will settle on, the index
    // of a pixel strobed now, and whether the current strobe paints ink.
    always_comb begin
        line_nxt = line_cnt;
        if (frame_start) begin
            line_nxt = '0;
        end else if (line_start && line_cnt != 12'hFFF) begin
            line_nxt = line_cnt + 12'd1;
        end
        pix_idx   = line_start ? 12'd0 : pix_cnt;
        in_window = (line_nxt >= WIN_LO) && (line_nxt < WIN_HI);
        row_off   = line_cnt - WIN_LO;
        paint     = pixel_valid && !line_start &&
                    ((state == SHIFT) || (state == ARMED && pix_idx == FIRST_X));
        rep_wrap  = (rep_cnt == REP_LAST);
        last_bit  = (bit_cnt == BIT_LAST);
    end

    // Line and pixel counters, both saturating at 4095.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_cnt <= '0;
            pix_cnt  <= '0;
        end else begin
            line_cnt <= line_nxt;
            if (pixel_valid) begin
                pix_cnt <= (pix_idx == 12'hFFF) ? pix_idx : pix_idx + 12'd1;
            end else begin
                pix_cnt <= pix_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a line_start in any state re-evaluates the new line from scratch.
    always_comb begin
        state_nxt = state;
        if (line_start) begin
            state_nxt = in_window ? ADDR : IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                ADDR:    state_nxt = WAIT;
                WAIT:    state_nxt = LOAD;
                LOAD:    state_nxt = ARMED;
                ARMED,
                SHIFT: begin
                    if (paint) begin
                        state_nxt = (rep_wrap && last_bit) ? DONE : SHIFT;
                    end
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Fetch address, line capture and the bit/replication serialiser.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_addr <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
        end else begin
            if (state == ADDR) begin
                rom_addr <= 4'(row_off / SCALE12);
            end
            if (state == LOAD) begin
                shreg   <= rom_q;
                bit_cnt <= '0;
                rep_cnt <= '0;
            end else if (paint) begin
                if (rep_wrap) begin
                    rep_cnt <= '0;
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + BW'(1);
                end else begin
                    rep_cnt <= rep_cnt + 2'd1;
                end
            end
        end
    end

    // Registered overlay outputs; ink can only appear alongside active.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            text_active <= 1'b0;
            text_pixel  <= 1'b0;
        end else begin
            text_active <= paint;
            text_pixel  <= paint & shreg[LINE_BITS-1];
        end
    end

endmodule
